// File: rtl/diff_line_codec.sv
// diff_line_codec: differential encode / decode of BITS_PER_BEAT bits per
// AXI-Stream beat (LSB first), with history carried across beats, optional
// restart on tlast, and a 2-entry output skid buffer with registered tready.
module diff_line_codec #(
  parameter int   C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int   C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int   BITS_PER_BEAT          = 1,
  parameter logic INIT_STATE             = 1'b1,
  parameter logic RESTART_ON_LAST        = 1'b1
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_areset,
  input  logic                                  mode,
  input  logic                                  s00_axis_tvalid,
  output logic                                  s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
  input  logic                                  s00_axis_tlast,
  output logic                                  m00_axis_tvalid,
  input  logic                                  m00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                  m00_axis_tlast,
  output logic [31:0]                           beat_count
);

  localparam int BPB = BITS_PER_BEAT;
  localparam int MW  = C_M00_AXIS_TDATA_WIDTH;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Differential chain over one beat. Result is {new_history, coded_bits}.
  // Encode feeds back the produced bit, decode feeds back the received bit.
  function automatic logic [BPB:0] code_beat(input logic [BPB-1:0] x,
                                             input logic           h,
                                             input logic           dec);
    logic           prev;
    logic [BPB-1:0] y;
    prev = h;
    y    = '0;
    for (int i = 0; i < BPB; i++) begin
      y[i] = x[i] ^ prev;
      if (dec) begin
        prev = x[i];
      end else begin
        prev = y[i];
      end
    end
    return {prev, y};
  endfunction

  skid_state_t      state_r;
  logic             valid_r;
  logic             tready_r;
  logic [MW-1:0]    head_data_r;
  logic             head_last_r;
  logic [MW-1:0]    skid_data_r;
  logic             skid_last_r;
  logic             hist_r;
  logic             last_mode_r;
  logic [31:0]      count_r;

  logic             accept_s;
  logic             drain_s;
  logic             h_eff_s;
  logic [BPB:0]     code_s;
  logic [MW-1:0]    coded_wide_s;
  logic             unused_s;

  // Handshakes, effective starting history and the coded beat.
  always_comb begin
    accept_s = s00_axis_tvalid && tready_r;
    drain_s  = valid_r && m00_axis_tready;
    if (mode != last_mode_r) begin
      h_eff_s = INIT_STATE;
    end else begin
      h_eff_s = hist_r;
    end
    code_s       = code_beat(s00_axis_tdata[BPB-1:0], h_eff_s, mode);
    coded_wide_s = '0;
    coded_wide_s[BPB-1:0] = code_s[BPB-1:0];
  end

  // Skid buffer FSM: head slot drives m00, skid slot absorbs one extra beat.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      state_r     <= EMPTY;
      valid_r     <= 1'b0;
      tready_r    <= 1'b1;
      head_data_r <= '0;
      head_last_r <= 1'b0;
      skid_data_r <= '0;
      skid_last_r <= 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            head_data_r <= coded_wide_s;
            head_last_r <= s00_axis_tlast;
            state_r     <= ONE;
            valid_r     <= 1'b1;
          end
          tready_r <= 1'b1;
        end
        ONE: begin
          if (accept_s && drain_s) begin
            head_data_r <= coded_wide_s;
            head_last_r <= s00_axis_tlast;
            tready_r    <= 1'b1;
          end else if (accept_s) begin
            skid_data_r <= coded_wide_s;
            skid_last_r <= s00_axis_tlast;
            state_r     <= FULL;
            tready_r    <= 1'b0;
          end else if (drain_s) begin
            state_r  <= EMPTY;
            valid_r  <= 1'b0;
            tready_r <= 1'b1;
          end else begin
            tready_r <= 1'b1;
          end
        end
        FULL: begin
          if (drain_s) begin
            head_data_r <= skid_data_r;
            head_last_r <= skid_last_r;
            state_r     <= ONE;
            tready_r    <= 1'b1;
          end else begin
            tready_r <= 1'b0;
          end
        end
        default: begin
          state_r  <= EMPTY;
          valid_r  <= 1'b0;
          tready_r <= 1'b1;
        end
      endcase
    end
  end

  // Coding history, mode memory and accepted-beat counter.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      hist_r      <= INIT_STATE;
      last_mode_r <= 1'b0;
      count_r     <= 32'd0;
    end else if (accept_s) begin
      last_mode_r <= mode;
      count_r     <= count_r + 32'd1;
      if (RESTART_ON_LAST && s00_axis_tlast) begin
        hist_r <= INIT_STATE;
      end else begin
        hist_r <= code_s[BPB];
      end
    end
  end

  // Input strobes and tdata bits above the coded field carry no information.
  assign unused_s = ^{s00_axis_tstrb, s00_axis_tdata};

  assign s00_axis_tready = tready_r;
  assign m00_axis_tvalid = valid_r;
  assign m00_axis_tdata  = head_data_r;
  assign m00_axis_tlast  = head_last_r;
  assign m00_axis_tstrb  = {(C_M00_AXIS_TDATA_WIDTH/8){1'b1}};
  assign beat_count      = count_r;

endmodule

// File: tb/tb_diff_line_codec.sv
// Bench for diff_line_codec: three instances share one stimulus stream.
//   a: 1-bit, INIT_STATE=1, RESTART_ON_LAST=1
//   b: 8-bit, INIT_STATE=0, RESTART_ON_LAST=1
//   c: 1-bit, INIT_STATE=1, RESTART_ON_LAST=0
module tb_diff_line_codec;

  logic        clk;
  logic        rst;
  logic        mode;
  logic        s_valid;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic        s_tlast;
  logic        m_ready;

  logic        a_tready, a_tvalid, a_tlast;
  logic [31:0] a_tdata, a_count;
  logic [3:0]  a_tstrb;
  logic        b_tready, b_tvalid, b_tlast;
  logic [31:0] b_tdata, b_count;
  logic [3:0]  b_tstrb;
  logic        c_tready, c_tvalid, c_tlast;
  logic [31:0] c_tdata, c_count;
  logic [3:0]  c_tstrb;

  int n_checks;
  int n_fail;

  diff_line_codec #(.BITS_PER_BEAT(1), .INIT_STATE(1'b1), .RESTART_ON_LAST(1'b1)) u_a (
    .s00_axis_aclk(clk), .s00_axis_areset(rst), .mode(mode),
    .s00_axis_tvalid(s_valid), .s00_axis_tready(a_tready), .s00_axis_tdata(s_tdata),
    .s00_axis_tstrb(s_tstrb), .s00_axis_tlast(s_tlast),
    .m00_axis_tvalid(a_tvalid), .m00_axis_tready(m_ready), .m00_axis_tdata(a_tdata),
    .m00_axis_tstrb(a_tstrb), .m00_axis_tlast(a_tlast), .beat_count(a_count));

  diff_line_codec #(.BITS_PER_BEAT(8), .INIT_STATE(1'b0), .RESTART_ON_LAST(1'b1)) u_b (
    .s00_axis_aclk(clk), .s00_axis_areset(rst), .mode(mode),
    .s00_axis_tvalid(s_valid), .s00_axis_tready(b_tready), .s00_axis_tdata(s_tdata),
    .s00_axis_tstrb(s_tstrb), .s00_axis_tlast(s_tlast),
    .m00_axis_tvalid(b_tvalid), .m00_axis_tready(m_ready), .m00_axis_tdata(b_tdata),
    .m00_axis_tstrb(b_tstrb), .m00_axis_tlast(b_tlast), .beat_count(b_count));

  diff_line_codec #(.BITS_PER_BEAT(1), .INIT_STATE(1'b1), .RESTART_ON_LAST(1'b0)) u_c (
    .s00_axis_aclk(clk), .s00_axis_areset(rst), .mode(mode),
    .s00_axis_tvalid(s_valid), .s00_axis_tready(c_tready), .s00_axis_tdata(s_tdata),
    .s00_axis_tstrb(s_tstrb), .s00_axis_tlast(s_tlast),
    .m00_axis_tvalid(c_tvalid), .m00_axis_tready(m_ready), .m00_axis_tdata(c_tdata),
    .m00_axis_tstrb(c_tstrb), .m00_axis_tlast(c_tlast), .beat_count(c_count));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        mode;
    logic [31:0] data;
    logic        last;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] exp_c;
  } vec_t;

  vec_t        vecs [14];
  logic        bp_bits [6];
  logic [31:0] bp_exp [6];
  int          in_idx;
  int          out_idx;
  logic        hs_in;
  logic        hs_out;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    //            mode  data    last  a      b       c
    vecs[0]  = '{1'b1, 32'h01, 1'b0, 32'h0, 32'h03, 32'h0};
    vecs[1]  = '{1'b1, 32'h01, 1'b0, 32'h0, 32'h03, 32'h0};
    vecs[2]  = '{1'b1, 32'h00, 1'b0, 32'h1, 32'h00, 32'h1};
    vecs[3]  = '{1'b1, 32'h00, 1'b0, 32'h0, 32'h00, 32'h0};
    vecs[4]  = '{1'b1, 32'h01, 1'b0, 32'h1, 32'h03, 32'h1};
    vecs[5]  = '{1'b0, 32'h0F, 1'b0, 32'h0, 32'h05, 32'h0};
    vecs[6]  = '{1'b1, 32'h05, 1'b0, 32'h0, 32'h0F, 32'h0};
    vecs[7]  = '{1'b1, 32'h00, 1'b0, 32'h1, 32'h00, 32'h1};
    vecs[8]  = '{1'b1, 32'h00, 1'b1, 32'h0, 32'h00, 32'h0};
    vecs[9]  = '{1'b1, 32'h00, 1'b0, 32'h1, 32'h00, 32'h0};
    vecs[10] = '{1'b0, 32'hA5, 1'b0, 32'h0, 32'h63, 32'h0};
    vecs[11] = '{1'b0, 32'h01, 1'b0, 32'h1, 32'hFF, 32'h1};
    vecs[12] = '{1'b0, 32'h00, 1'b1, 32'h1, 32'hFF, 32'h1};
    vecs[13] = '{1'b0, 32'h00, 1'b0, 32'h1, 32'h00, 32'h1};
    bp_bits[0] = 1'b0; bp_bits[1] = 1'b0; bp_bits[2] = 1'b1;
    bp_bits[3] = 1'b1; bp_bits[4] = 1'b0; bp_bits[5] = 1'b1;
    bp_exp[0] = 32'd1; bp_exp[1] = 32'd0; bp_exp[2] = 32'd1;
    bp_exp[3] = 32'd0; bp_exp[4] = 32'd1; bp_exp[5] = 32'd1;

    // Reset state
    rst = 1'b1; mode = 1'b0; s_valid = 1'b0; s_tdata = 32'd0;
    s_tstrb = 4'hF; s_tlast = 1'b0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", {31'd0, a_tvalid}, 32'd0);
    check("rst_tdata", a_tdata, 32'd0);
    check("rst_tlast", {31'd0, a_tlast}, 32'd0);
    check("rst_count", a_count, 32'd0);
    check("tstrb", {28'd0, a_tstrb}, 32'hF);
    rst = 1'b0;
    check("rel_tready", {31'd0, a_tready}, 32'd1);

    // Table: continuous beats, m_ready high, each output one cycle after accept
    for (int i = 0; i < 14; i++) begin
      mode = vecs[i].mode; s_tdata = vecs[i].data; s_tlast = vecs[i].last; s_valid = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_a", i), a_tdata, vecs[i].exp_a);
      check($sformatf("vec%0d_b", i), b_tdata, vecs[i].exp_b);
      check($sformatf("vec%0d_c", i), c_tdata, vecs[i].exp_c);
      check($sformatf("vec%0d_last", i), {31'd0, a_tlast}, {31'd0, vecs[i].last});
      check($sformatf("vec%0d_valid", i), {31'd0, a_tvalid}, 32'd1);
      check($sformatf("vec%0d_tready", i), {31'd0, a_tready}, 32'd1);
    end
    s_valid = 1'b0; s_tlast = 1'b0;
    @(posedge clk);
    #1;
    check("table_drained", {31'd0, a_tvalid}, 32'd0);
    check("table_count", a_count, 32'd14);

    // Backpressure: m_ready low for 4 cycles, then drain
    in_idx = 0; out_idx = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (in_idx == 6 && out_idx == 6) break;
      m_ready = (cyc >= 4);
      mode = 1'b1; s_tlast = 1'b0;
      s_valid = (in_idx < 6);
      if (in_idx < 6) s_tdata = {31'd0, bp_bits[in_idx]};
      else s_tdata = 32'd0;
      if (cyc >= 1 && cyc < 4) check("stall_hold", a_tdata, 32'd1);
      if (cyc == 4) begin
        check("stall_accepts", in_idx, 32'd2);
        check("stall_tready", {31'd0, a_tready}, 32'd0);
      end
      hs_in  = s_valid && a_tready;
      hs_out = a_tvalid && m_ready;
      if (hs_out) begin
        if (out_idx < 6) check($sformatf("drain%0d", out_idx), a_tdata, bp_exp[out_idx]);
        out_idx++;
      end
      if (hs_in) in_idx++;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    check("drain_count", out_idx, 32'd6);
    check("drain_empty", {31'd0, a_tvalid}, 32'd0);
    check("bp_count", a_count, 32'd20);

    // Throughput: 10 back-to-back beats with simultaneous accept and drain
    m_ready = 1'b1; mode = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s_valid = 1'b1;
      s_tdata = (k % 2 == 0) ? 32'd1 : 32'd0;
      @(posedge clk);
      #1;
      check($sformatf("tput%0d_data", k), a_tdata, (k == 0) ? 32'd0 : 32'd1);
      check($sformatf("tput%0d_tready", k), {31'd0, a_tready}, 32'd1);
    end
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    check("tput_count", a_count, 32'd30);

    // Fill to FULL, then asynchronous reset between clock edges
    m_ready = 1'b0; s_valid = 1'b1; s_tdata = 32'd0; mode = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    check("full_tvalid", {31'd0, a_tvalid}, 32'd1);
    check("full_tready", {31'd0, a_tready}, 32'd0);
    check("full_count", a_count, 32'd32);
    #3;
    rst = 1'b1;
    #1;
    check("arst_tvalid", {31'd0, a_tvalid}, 32'd0);
    check("arst_count", a_count, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ready = 1'b1;
    check("arst_tready", {31'd0, a_tready}, 32'd1);
    // Encode 0 with no mode change: output equals the reset history
    mode = 1'b0; s_tdata = 32'd0; s_valid = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_enc", a_tdata, 32'd1);
    check("post_rst_count1", a_count, 32'd1);
    // Decode 0: restarts from INIT_STATE
    mode = 1'b1; s_tdata = 32'd0;
    @(posedge clk);
    #1;
    check("post_rst_dec", a_tdata, 32'd1);
    check("post_rst_count2", a_count, 32'd2);
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    check("final_empty", {31'd0, a_tvalid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
